// File: rtl/pc_control.sv
// pc_control: next-PC selection for B / BR / HLT / sequential control flow.
// PC_out and taken are combinational; the only state is the halt status.
// Optional feature macro: PC_CONTROL_HALT_EN enables the HLT opcode and the
// halted register. Without it, HLT decodes as sequential and no flop exists.
module pc_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  opcode,
    input  logic [2:0]  C,
    input  logic [8:0]  I,
    input  logic [2:0]  F,
    input  logic [15:0] PC_in,
    input  logic [15:0] data_in,
    output logic [15:0] PC_out,
    output logic        taken,
    output logic        halted
);

    localparam logic [1:0] OP_B   = 2'b00;
    localparam logic [1:0] OP_BR  = 2'b01;
    localparam logic [1:0] OP_HLT = 2'b10;
    localparam logic [1:0] OP_SEQ = 2'b11;

    logic [15:0] w_seq;
    logic [15:0] w_offset;
    logic [15:0] w_bTarget;
    logic        w_cond;
    logic        w_zero;
    logic        w_ovf;
    logic        w_neg;
    logic        w_halted;

    assign w_zero = F[2];
    assign w_ovf  = F[1];
    assign w_neg  = F[0];

    // Sequential PC and PC-relative target; the word offset becomes a byte offset.
    assign w_seq     = PC_in + 16'd2;
    assign w_offset  = {{6{I[8]}}, I, 1'b0};
    assign w_bTarget = w_seq + w_offset;

    // Branch condition evaluation from the condition code and ALU flags.
    always_comb begin
        w_cond = 1'b0;
        case (C)
            3'b000:  w_cond = ~w_zero;
            3'b001:  w_cond = w_zero;
            3'b010:  w_cond = ~w_zero & ~w_neg;
            3'b011:  w_cond = w_neg;
            3'b100:  w_cond = w_zero | (~w_zero & ~w_neg);
            3'b101:  w_cond = w_neg | w_zero;
            3'b110:  w_cond = w_ovf;
            default: w_cond = 1'b1;
        endcase
    end

`ifdef PC_CONTROL_HALT_EN
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_nextState;

    // Halt status register; reset clears it immediately without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // An HLT while running parks the machine; only reset leaves the halt state.
    always_comb begin
        w_nextState = r_state;
        if (r_state == ST_RUN && opcode == OP_HLT) begin
            w_nextState = ST_HALT;
        end
    end

    assign w_halted = (r_state == ST_HALT);
`else
    logic w_unusedClkRst;

    // Clock and reset have nothing to drive when HLT support is compiled out.
    assign w_unusedClkRst = clk ^ rst_n;
    assign w_halted       = 1'b0;
`endif

    assign halted = w_halted;

    // Next-PC mux; a halted core holds its PC regardless of the opcode.
    always_comb begin
        PC_out = w_seq;
        taken  = 1'b0;
        if (w_halted) begin
            PC_out = PC_in;
        end else begin
            case (opcode)
                OP_B: begin
                    taken  = w_cond;
                    PC_out = w_cond ? w_bTarget : w_seq;
                end
                OP_BR: begin
                    taken  = w_cond;
                    PC_out = w_cond ? data_in : w_seq;
                end
`ifdef PC_CONTROL_HALT_EN
                OP_HLT: begin
                    PC_out = PC_in;
                end
`else
                OP_HLT: begin
                    PC_out = w_seq;
                end
`endif
                OP_SEQ: begin
                    PC_out = w_seq;
                end
                default: begin
                    PC_out = w_seq;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_control.sv
// Testbench for pc_control: directed vector table, exhaustive condition sweep,
// randomized checks against an arithmetic reference model, and halt sequences.
module tb_pc_control;

    logic        clk;
    logic        rst_n;
    logic [1:0]  opcode;
    logic [2:0]  C;
    logic [8:0]  I;
    logic [2:0]  F;
    logic [15:0] PC_in;
    logic [15:0] data_in;
    logic [15:0] PC_out;
    logic        taken;
    logic        halted;

    int assertCount;
    int failCount;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  c;
        logic [8:0]  i;
        logic [2:0]  f;
        logic [15:0] pc;
        logic [15:0] data;
        logic [15:0] expPc;
        logic        expTaken;
    } vector_t;

    vector_t vecs [10];

    pc_control dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .opcode  (opcode),
        .C       (C),
        .I       (I),
        .F       (F),
        .PC_in   (PC_in),
        .data_in (data_in),
        .PC_out  (PC_out),
        .taken   (taken),
        .halted  (halted)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference condition straight from the flag table.
    function automatic bit modelCond(input logic [2:0] c, input logic [2:0] f);
        bit z, v, n;
        z = f[2];
        v = f[1];
        n = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    // Reference next PC using integer arithmetic; returns {taken, pc}.
    function automatic logic [16:0] modelNext(input logic [1:0] op, input logic [2:0] c,
                                              input logic [8:0] i, input logic [2:0] f,
                                              input logic [15:0] pc, input logic [15:0] data);
        int sI;
        int tgt;
        int seqPc;
        bit cnd;
        seqPc = (int'(pc) + 2) % 65536;
        sI = int'(i);
        if (sI >= 256) sI = sI - 512;
        tgt = ((int'(pc) + 2 + sI * 2) % 65536 + 65536) % 65536;
        cnd = modelCond(c, f);
        if (op == 2'd0) return cnd ? {1'b1, tgt[15:0]} : {1'b0, seqPc[15:0]};
        if (op == 2'd1) return cnd ? {1'b1, data} : {1'b0, seqPc[15:0]};
        return {1'b0, seqPc[15:0]};
    endfunction

    task automatic applyStimulus(input logic [1:0] op, input logic [2:0] c, input logic [8:0] i,
                                 input logic [2:0] f, input logic [15:0] pc, input logic [15:0] data);
        opcode  = op;
        C       = c;
        I       = i;
        F       = f;
        PC_in   = pc;
        data_in = data;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    initial begin
        logic [16:0] exp;
        logic [1:0]  rOp;
        assertCount = 0;
        failCount   = 0;

        vecs[0] = '{2'b00, 3'd7, 9'h003, 3'd0, 16'h0001, 16'h0000, 16'h0009, 1'b1};
        vecs[1] = '{2'b01, 3'd7, 9'h000, 3'd0, 16'h0001, 16'h111F, 16'h111F, 1'b1};
        vecs[2] = '{2'b01, 3'd0, 9'h000, 3'd4, 16'h0001, 16'h111F, 16'h0003, 1'b0};
        vecs[3] = '{2'b00, 3'd7, 9'h1FF, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        vecs[4] = '{2'b11, 3'd0, 9'h000, 3'd0, 16'hFFFE, 16'h0000, 16'h0000, 1'b0};
        vecs[5] = '{2'b11, 3'd7, 9'h1FF, 3'd7, 16'h1000, 16'hABCD, 16'h1002, 1'b0};
        vecs[6] = '{2'b00, 3'd0, 9'h100, 3'd0, 16'h0000, 16'h0000, 16'hFE02, 1'b1};
        vecs[7] = '{2'b01, 3'd6, 9'h000, 3'd2, 16'h2000, 16'h1235, 16'h1235, 1'b1};
        vecs[8] = '{2'b00, 3'd3, 9'h0FF, 3'd0, 16'h4000, 16'h0000, 16'h4002, 1'b0};
        vecs[9] = '{2'b00, 3'd1, 9'h0FF, 3'd4, 16'hFFF0, 16'h0000, 16'h01F0, 1'b1};

        // Reset held: halted clear, combinational path still live.
        rst_n = 1'b0;
        applyStimulus(2'b00, 3'd7, 9'h003, 3'd0, 16'h0001, 16'h0000);
        checkOutput("reset_halted", {15'd0, halted}, 16'd0);
        checkOutput("reset_pc", PC_out, 16'h0009);
        checkOutput("reset_taken", {15'd0, taken}, 16'd1);
        #13;
        rst_n = 1'b1;

        // Directed vector table.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(vecs[k].op, vecs[k].c, vecs[k].i, vecs[k].f, vecs[k].pc, vecs[k].data);
            checkOutput($sformatf("vec%0d_pc", k), PC_out, vecs[k].expPc);
            checkOutput($sformatf("vec%0d_taken", k), {15'd0, taken}, {15'd0, vecs[k].expTaken});
        end

        // Exhaustive condition sweep over B and BR.
        for (int op = 0; op < 2; op++) begin
            for (int c = 0; c < 8; c++) begin
                for (int f = 0; f < 8; f++) begin
                    applyStimulus(op[1:0], c[2:0], 9'h005, f[2:0], 16'h0100, 16'h0BEE);
                    checkOutput($sformatf("sweep_op%0d_c%0d_f%0d", op, c, f),
                                {15'd0, taken}, {15'd0, modelCond(c[2:0], f[2:0])});
                end
            end
        end

        // Randomized stimulus against the reference model; HLT kept out when it would halt.
        for (int k = 0; k < 300; k++) begin
`ifdef PC_CONTROL_HALT_EN
            rOp = 2'($urandom_range(0, 2));
            if (rOp == 2'd2) rOp = 2'd3;
`else
            rOp = 2'($urandom_range(0, 3));
`endif
            applyStimulus(rOp, 3'($urandom), 9'($urandom), 3'($urandom), 16'($urandom), 16'($urandom));
            exp = modelNext(opcode, C, I, F, PC_in, data_in);
            checkOutput($sformatf("rand%0d_pc", k), PC_out, exp[15:0]);
            checkOutput($sformatf("rand%0d_taken", k), {15'd0, taken}, {15'd0, exp[16]});
            checkOutput($sformatf("rand%0d_halted", k), {15'd0, halted}, 16'd0);
            if (k % 16 == 0) @(negedge clk);
        end

`ifdef PC_CONTROL_HALT_EN
        // HLT: PC held immediately, halted rises on the next edge and sticks.
        @(negedge clk);
        applyStimulus(2'b10, 3'd0, 9'h000, 3'd0, 16'h1234, 16'h0000);
        checkOutput("hlt_pre_halted", {15'd0, halted}, 16'd0);
        checkOutput("hlt_pre_pc", PC_out, 16'h1234);
        @(posedge clk);
        #1;
        checkOutput("hlt_halted", {15'd0, halted}, 16'd1);
        checkOutput("hlt_pc", PC_out, 16'h1234);
        applyStimulus(2'b00, 3'd7, 9'h003, 3'd0, 16'h1234, 16'h0000);
        checkOutput("halted_b_pc", PC_out, 16'h1234);
        checkOutput("halted_b_taken", {15'd0, taken}, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("halted_sticky", {15'd0, halted}, 16'd1);
        applyStimulus(2'b01, 3'd7, 9'h000, 3'd0, 16'h2222, 16'hAAAA);
        checkOutput("halted_br_pc", PC_out, 16'h2222);
        // Mid-cycle reset pulse clears halted without a clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_halted", {15'd0, halted}, 16'd0);
        checkOutput("rst_async_pc", PC_out, 16'hAAAA);
        // HLT present at reset release halts only on the following edge.
        applyStimulus(2'b10, 3'd0, 9'h000, 3'd0, 16'h3000, 16'h0000);
        rst_n = 1'b1;
        #1;
        checkOutput("rel_halted_low", {15'd0, halted}, 16'd0);
        @(posedge clk);
        #1;
        checkOutput("rel_halted_high", {15'd0, halted}, 16'd1);
`else
        // HLT compiled out: behaves as sequential and never halts.
        @(negedge clk);
        applyStimulus(2'b10, 3'd7, 9'h003, 3'd0, 16'h1234, 16'h5555);
        checkOutput("nohlt_pc", PC_out, 16'h1236);
        checkOutput("nohlt_taken", {15'd0, taken}, 16'd0);
        @(posedge clk);
        #1;
        checkOutput("nohlt_halted", {15'd0, halted}, 16'd0);
        checkOutput("nohlt_pc_after", PC_out, 16'h1236);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/pc_control.md
PC_CONTROL -- requirements
Module: pc_control

Interface
- REQ-001: No parameters.
- REQ-002: clk  input  1  rising-edge clock; clocks only the halt state.
- REQ-003: rst_n  input  1  reset, asynchronous, active-low.
- REQ-004: opcode  input  2  control-flow class: 00 B (PC-relative), 01 BR (register), 10 HLT, 11 sequential.
- REQ-005: C  input  3  branch condition code.
- REQ-006: I  input  9  signed word offset for B.
- REQ-007: F  input  3  ALU flags: F[2]=Z, F[1]=V, F[0]=N.
- REQ-008: PC_in  input  16  current PC, byte address.
- REQ-009: data_in  input  16  register-sourced target for BR.
- REQ-010: PC_out  output  16  next PC, combinational.
- REQ-011: taken  output  1  branch taken this cycle, combinational.
- REQ-012: halted  output  1  registered halt status.

Function
- REQ-013: Compute seq = PC_in + 2, modulo 2^16, wrapping silently.
- REQ-014: Evaluate cond from C and F:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GTE: Z=1 or (Z=0 and N=0)
  - 101 LTE: N=1 or Z=1
  - 110 OVF: V=1
  - 111 UNCOND: always 1
- REQ-015: B target = seq + (sign_extend16(I) << 1), modulo 2^16; I=0x1FF means -2 bytes.
- REQ-016: BR target = data_in unmodified; no alignment masking.
- REQ-017: opcode 00: PC_out = cond ? B target : seq; taken = cond.
- REQ-018: opcode 01: PC_out = cond ? data_in : seq; taken = cond.
- REQ-019: opcode 11: PC_out = seq; taken = 0; C, F, I and data_in are ignored.
- REQ-020: opcode 10 (HLT enabled): PC_out = PC_in; taken = 0; halted sets to 1 on the next rising clk edge.
- REQ-021: While halted=1: PC_out = PC_in and taken = 0 for every opcode; halted stays 1 until reset.
- REQ-022: PC_out and taken are purely combinational from the inputs and halted; zero-cycle latency, no latches.
- REQ-023: An X-free input set yields X-free outputs; all 8 C codes and all 4 opcodes are fully decoded.

Reset
- REQ-024: rst_n low clears halted to 0 immediately, independent of clk.
- REQ-025: While rst_n is low, PC_out and taken follow the combinational rules with halted=0.
- REQ-026: An HLT present at the edge where rst_n deasserts takes effect on the following rising clk edge only.

Configuration
- REQ-027: Macro PC_CONTROL_HALT_EN, when defined, enables the HLT behaviour of REQ-020 and REQ-021.
- REQ-028: Without PC_CONTROL_HALT_EN:
  - opcode 10 behaves exactly as opcode 11;
  - halted is tied to 0;
  - no flip-flop is inferred.

Verification
- REQ-029: opcode 00, C=111, I=0x003, PC_in=0x0001 -> PC_out=0x0009, taken=1.
- REQ-030: opcode 01, C=111, data_in=0x111F, PC_in=0x0001 -> PC_out=0x111F. Same with C=000, F=100 (Z=1) -> PC_out=0x0003, taken=0.
- REQ-031: opcode 00, C=111, I=0x1FF, PC_in=0x0000 -> PC_out=0x0000 (negative offset wraps).
- REQ-032: opcode 11, PC_in=0xFFFE -> PC_out=0x0000, taken=0.
- REQ-033: Exhaustive sweep, opcode 00/01 × C 0..7 × F 0..7 -> taken matches the REQ-014 table for all 128 combinations.
- REQ-034: HALT_EN defined, opcode 10, one clk edge:
  - halted=1 and PC_out=PC_in;
  - then opcode 00, C=111 -> PC_out still equals PC_in;
  - pulse rst_n low mid-cycle -> halted=0 at once.
